prog_sequencer: RTL and testbench

- Parametrised program-flow and run controller for the 9-bit ISA core; successor to the fixed PC / PC_Controller pair and the bare req/done top-level handshake.
- Owns the program counter, multiple selectable program entry points, absolute and relative branching, stall, halt detection, a cycle counter and a watchdog timeout.
- Sits between the host req/done interface and instr_ROM, Control and the decoder. Its `run` output gates RegWrite/MemWrite in the core.

---
 rtl/prog_sequencer.sv | 127 ++++++++++++
 tb/tb_prog_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// ============================================================================
//  Module      : prog_sequencer
//  Description : Program-flow and run controller for the 9-bit ISA core.
//                Owns the PC, entry-point selection, branching, stall,
//                halt detection, a RUN-cycle counter and a watchdog.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module prog_sequencer #(
    parameter int D          = 12,
    parameter int NPROG      = 4,
    parameter int CW         = 16,
    parameter int MAX_CYCLES = 4096,
    localparam int PSW       = (NPROG > 1) ? $clog2(NPROG) : 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 req_i,
    input  logic [PSW-1:0]       prog_sel_i,
    input  logic [NPROG*D-1:0]   entry_tbl_i,
    input  logic                 halt_i,
    input  logic                 jump_en_i,
    input  logic                 jump_abs_i,
    input  logic [D-1:0]         target_i,
    input  logic                 stall_i,
    output logic [D-1:0]         prog_ctr_o,
    output logic                 run_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic [CW-1:0]        cycle_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [D-1:0]   pc_q, pc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           to_q, to_d;
    logic [D-1:0]   entry_sel;
    logic           wd_hit;

    // Out-of-range selectors fall back to entry 0.
    always_comb begin
        entry_sel = entry_tbl_i[D-1:0];
        for (int i = 1; i < NPROG; i++) begin
            if (prog_sel_i == PSW'(i)) begin
                entry_sel = entry_tbl_i[i*D +: D];
            end
        end
    end

    assign wd_hit = (cnt_q == CW'(MAX_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    pc_d    = entry_sel;
                    cnt_d   = '0;
                    to_d    = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: state_d = RUN;
            RUN: begin
                if (halt_i) begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = DONE;
                end else if (wd_hit) begin
                    // Counter holds here so MAX_CYCLES = 2^CW cannot wrap it.
                    to_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (!stall_i) begin
                        if (jump_en_i) begin
                            pc_d = jump_abs_i ? target_i : (pc_q + target_i);
                        end else begin
                            pc_d = pc_q + D'(1);
                        end
                    end
                end
            end
            DONE: begin
                if (!req_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    assign prog_ctr_o  = pc_q;
    assign run_o       = (state_q == RUN);
    assign busy_o      = (state_q == LOAD) || (state_q == RUN);
    assign done_o      = (state_q == DONE);
    assign timeout_o   = to_q;
    assign cycle_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_sequencer.sv
// ============================================================================
//  Module      : tb_prog_sequencer
//  Description : Bench for prog_sequencer; two instances (NPROG=4/MAX=8 and
//                NPROG=3/MAX=4096) checked against a phase-level model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prog_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [1:0]  sel = '0;
    logic [47:0] tbl = '0;
    logic        halt = 1'b0, jen = 1'b0, jabs = 1'b0, stall = 1'b0;
    logic [11:0] tgt = '0;

    logic [11:0] pcA, pcB;
    logic        runA, busyA, doneA, toA, runB, busyB, doneB, toB;
    logic [15:0] cntA, cntB;

    always #5 clk = ~clk;

    prog_sequencer #(.D(12), .NPROG(4), .CW(16), .MAX_CYCLES(8)) u_dut_a (
        .clk_i(clk), .reset_i(reset), .req_i(req), .prog_sel_i(sel),
        .entry_tbl_i(tbl), .halt_i(halt), .jump_en_i(jen), .jump_abs_i(jabs),
        .target_i(tgt), .stall_i(stall), .prog_ctr_o(pcA), .run_o(runA),
        .busy_o(busyA), .done_o(doneA), .timeout_o(toA), .cycle_cnt_o(cntA)
    );

    prog_sequencer #(.D(12), .NPROG(3), .CW(16), .MAX_CYCLES(4096)) u_dut_b (
        .clk_i(clk), .reset_i(reset), .req_i(req), .prog_sel_i(sel),
        .entry_tbl_i(tbl[35:0]), .halt_i(halt), .jump_en_i(jen), .jump_abs_i(jabs),
        .target_i(tgt), .stall_i(stall), .prog_ctr_o(pcB), .run_o(runB),
        .busy_o(busyB), .done_o(doneB), .timeout_o(toB), .cycle_cnt_o(cntB)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: ph 0=waiting for req, 1=fetch bubble, 2=executing, 3=finished.
    typedef struct {
        int ph;
        int pc;
        int cnt;
        bit to;
    } mst_t;

    mst_t mA = '{0, 0, 0, 1'b0};
    mst_t mB = '{0, 0, 0, 1'b0};

    function automatic mst_t mstep(mst_t s, int nprog, int maxc);
        mst_t n = s;
        int off;
        if (reset) return '{0, 0, 0, 1'b0};
        case (s.ph)
            0: if (req) begin
                n.pc  = (int'(sel) < nprog) ? int'(tbl[int'(sel)*12 +: 12]) : int'(tbl[11:0]);
                n.cnt = 0;
                n.to  = 1'b0;
                n.ph  = 1;
            end
            1: n.ph = 2;
            2: begin
                if (halt) begin
                    n.cnt = s.cnt + 1;
                    n.ph  = 3;
                end else if (s.cnt == maxc - 1) begin
                    n.to = 1'b1;
                    n.ph = 3;
                end else begin
                    n.cnt = s.cnt + 1;
                    if (stall) n.pc = s.pc;
                    else if (jen && jabs) n.pc = int'(tgt);
                    else if (jen) begin
                        off  = int'(tgt);
                        if (off >= 2048) off -= 4096;
                        n.pc = (s.pc + off + 4096) % 4096;
                    end else n.pc = (s.pc + 1) % 4096;
                end
            end
            default: if (!req) n.ph = 0;
        endcase
        return n;
    endfunction

    always @(posedge clk) begin
        mA <= mstep(mA, 4, 8);
        mB <= mstep(mB, 3, 4096);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("A_pc", 32'(pcA), 32'(mA.pc));
            chk("A_run", 32'(runA), 32'(mA.ph == 2));
            chk("A_busy", 32'(busyA), 32'(mA.ph == 1 || mA.ph == 2));
            chk("A_done", 32'(doneA), 32'(mA.ph == 3));
            chk("A_timeout", 32'(toA), 32'(mA.to));
            chk("A_cnt", 32'(cntA), 32'(mA.cnt));
            chk("B_pc", 32'(pcB), 32'(mB.pc));
            chk("B_run", 32'(runB), 32'(mB.ph == 2));
            chk("B_busy", 32'(busyB), 32'(mB.ph == 1 || mB.ph == 2));
            chk("B_done", 32'(doneB), 32'(mB.ph == 3));
            chk("B_timeout", 32'(toB), 32'(mB.to));
            chk("B_cnt", 32'(cntB), 32'(mB.cnt));
        end
    end

    // Per-RUN-cycle control script; index = RUN cycle number of instance B.
    bit   s_halt[16], s_jen[16], s_jabs[16], s_stall[16];
    logic [11:0] s_tgt[16];
    int   scr_len = 0;

    task automatic clr_script();
        for (int i = 0; i < 16; i++) begin
            s_halt[i] = 0; s_jen[i] = 0; s_jabs[i] = 0; s_stall[i] = 0; s_tgt[i] = '0;
        end
        scr_len = 0;
    endtask

    task automatic set_step(input int k, input bit h, input bit je, input bit ja,
                            input logic [11:0] t, input bit st);
        s_halt[k] = h; s_jen[k] = je; s_jabs[k] = ja; s_tgt[k] = t; s_stall[k] = st;
        if (k + 1 > scr_len) scr_len = k + 1;
    endtask

    // Starts a program and returns at the negedge where B shows done
    // (or right after reset was applied when rst_k is reached).
    task automatic exec(input logic [1:0] s, input int rst_k, input int drop_k);
        int k = 0;
        bit fin = 0;
        sel = s;
        req = 1'b1;
        for (int c = 0; c < 80 && !fin; c++) begin
            @(negedge clk);
            halt = 0; jen = 0; jabs = 0; tgt = '0; stall = 0; reset = 0;
            if (doneB) fin = 1;
            else if (runB) begin
                if (k == drop_k) req = 1'b0;
                if (k == rst_k) begin
                    reset = 1'b1;
                    req   = 1'b0;
                    fin   = 1;
                end else if (k < scr_len) begin
                    halt = s_halt[k]; jen = s_jen[k]; jabs = s_jabs[k];
                    tgt = s_tgt[k]; stall = s_stall[k];
                end else halt = 1'b1;
                k++;
            end
        end
        if (!fin) begin
            n_cmp++;
            n_bad++;
            $display("FAIL exec_timeout: got no done expected done within 80 cycles");
        end
    endtask

    task automatic release_req();
        req = 1'b0;
        @(negedge clk);
        chk("release_done", 32'(doneB), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_pc", 32'(pcB), 32'h0);
        chk("rst_busy", 32'(busyB), 32'd0);
        chk("rst_done", 32'(doneB), 32'd0);
        chk("rst_cnt", 32'(cntB), 32'd0);

        // Basic run from entry 2
        tbl = {12'h3FF, 12'h200, 12'h100, 12'h010};
        clr_script(); set_step(3, 1, 0, 0, '0, 0);
        exec(2'd2, -1, -1);
        chk("basic_pc", 32'(pcB), 32'h203);
        chk("basic_cnt", 32'(cntB), 32'd4);
        chk("basic_to", 32'(toB), 32'd0);
        chk("basic_done", 32'(doneB), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_done", 32'(doneB), 32'd1);
            chk("hold_busy", 32'(busyB), 32'd0);
        end
        release_req();
        chk("idle_pc", 32'(pcB), 32'h203);

        // Branching from entry 1; A (MAX=8) trips the watchdog along the way
        clr_script();
        set_step(5, 0, 1, 0, 12'hFFD, 0);
        set_step(8, 0, 1, 1, 12'h7F0, 1);
        set_step(9, 0, 1, 1, 12'h7F0, 0);
        set_step(10, 1, 0, 0, '0, 0);
        exec(2'd1, -1, -1);
        chk("br_pc", 32'(pcB), 32'h7F0);
        chk("br_cnt", 32'(cntB), 32'd11);
        chk("wd_pcA", 32'(pcA), 32'h103);
        chk("wd_cntA", 32'(cntA), 32'd7);
        chk("wd_toA", 32'(toA), 32'd1);
        release_req();

        // Wrap around the top of the address space
        tbl = {12'h3FF, 12'h200, 12'h100, 12'hFFE};
        clr_script(); set_step(3, 1, 0, 0, '0, 0);
        exec(2'd0, -1, -1);
        chk("wrap_pc", 32'(pcB), 32'h001);
        release_req();
        clr_script(); set_step(0, 0, 1, 0, 12'h005, 0); set_step(1, 1, 0, 0, '0, 0);
        exec(2'd0, -1, -1);
        chk("wraprel_pc", 32'(pcB), 32'h003);
        chk("wraprel_cnt", 32'(cntB), 32'd2);
        release_req();

        // Halt coinciding with the watchdog limit on A
        clr_script(); set_step(7, 1, 0, 0, '0, 0);
        exec(2'd0, -1, -1);
        chk("wdh_toA", 32'(toA), 32'd0);
        chk("wdh_cntA", 32'(cntA), 32'd8);
        chk("wdh_pcA", 32'(pcA), 32'h005);
        release_req();

        // Reset mid-RUN at PC 0x105, then a clean restart
        clr_script(); set_step(10, 1, 0, 0, '0, 0);
        exec(2'd1, 5, -1);
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_pc", 32'(pcB), 32'h0);
        chk("mrst_run", 32'(runB), 32'd0);
        chk("mrst_done", 32'(doneB), 32'd0);
        chk("mrst_cnt", 32'(cntB), 32'd0);
        clr_script(); set_step(3, 1, 0, 0, '0, 0);
        exec(2'd2, -1, -1);
        chk("restart_pc", 32'(pcB), 32'h203);
        release_req();

        // req dropped in RUN: program still completes, done lasts one cycle
        exec(2'd2, -1, 1);
        chk("drop_cnt", 32'(cntB), 32'd4);
        @(negedge clk);
        chk("drop_done", 32'(doneB), 32'd0);
        clr_script(); set_step(1, 1, 0, 0, '0, 0);
        exec(2'd0, -1, -1);
        chk("second_cnt", 32'(cntB), 32'd2);
        release_req();

        // Randomized traffic, checked cycle by cycle against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 199) == 0);
            if (mA.ph == 0 && mB.ph == 0 && $urandom_range(0, 9) == 0)
                tbl = {$urandom(), $urandom()};
            if (!req) req = ($urandom_range(0, 3) == 0);
            else      req = ($urandom_range(0, 15) != 0);
            sel   = 2'($urandom_range(0, 3));
            halt  = ($urandom_range(0, 9) == 0);
            jen   = ($urandom_range(0, 3) == 0);
            jabs  = 1'($urandom_range(0, 1));
            tgt   = 12'($urandom());
            stall = ($urandom_range(0, 4) == 0);
        end
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
